// File: rtl/tx_frame_sched.sv
// Round-robin scheduler that hands frames from N_SRC sources to one serial
// transmitter, enforcing an inter-frame gap and a per-frame busy timeout.
`ifndef CH_NUM
`define CH_NUM 4
`endif
`ifndef BUFF_SIZE
`define BUFF_SIZE 8
`endif

module tx_frame_sched #(
  parameter int N_SRC   = 4,
  parameter int FRAME_W = `CH_NUM * `BUFF_SIZE,
  parameter int GAP_CYC = 2,
  parameter int TMO_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_SRC-1:0]         req,
  input  logic [N_SRC*FRAME_W-1:0] frame_in,
  output logic [N_SRC-1:0]         ack,
  output logic [FRAME_W-1:0]       tx_data,
  output logic                     tx_ena,
  input  logic                     tx_busy,
  output logic [$clog2(N_SRC)-1:0] grant_id,
  output logic                     active,
  output logic                     tmo_err,
  output logic [15:0]              frame_cnt,
  output logic [1:0]               state_dbg
);

  // Handshake: a source raises req[i] (level) with its frame stable on
  // frame_in and holds both until ack[i] pulses for one cycle in LAUNCH; a
  // req dropped earlier is simply never granted.

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

  localparam int GID_W = $clog2(N_SRC);
  localparam int TMO_W = ($clog2(TMO_CYC + 1) > 10) ? $clog2(TMO_CYC + 1) : 10;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
  localparam logic [7:0]       GAP_LAST = (GAP_CYC > 0) ? 8'(GAP_CYC - 1) : 8'd0;

  state_t           state, state_nx;
  logic [GID_W-1:0] last_grant;
  logic [GID_W-1:0] winner;
  logic [GID_W-1:0] idx;
  logic             any_req;
  logic [TMO_W-1:0] tmo_cnt;
  logic [7:0]       gap_cnt;
  logic             frame_done;
  logic             frame_tmo;
  logic             launch_go;

  // Search starts one past the last grant so every source gets a turn.
  always_comb begin
    winner  = last_grant;
    any_req = 1'b0;
    idx     = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      idx = GID_W'((int'(last_grant) + k) % N_SRC);
      if (!any_req && req[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

  assign frame_done = (state == WAIT_DONE) && !tx_busy;
  assign frame_tmo  = (state == WAIT_DONE) && tx_busy && (tmo_cnt == TMO_LAST);
  assign launch_go  = (state == IDLE) && any_req && !tx_busy;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (launch_go) state_nx = LAUNCH;
      LAUNCH:    state_nx = WAIT_DONE;
      WAIT_DONE: if (frame_done || frame_tmo) state_nx = (GAP_CYC == 0) ? IDLE : GAP;
      GAP:       if (gap_cnt == GAP_LAST) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GID_W'(N_SRC - 1);
      grant_id   <= '0;
      tx_data    <= '0;
      tmo_cnt    <= '0;
      gap_cnt    <= '0;
      tmo_err    <= 1'b0;
      frame_cnt  <= 16'd0;
    end else begin
      state <= state_nx;
      if (launch_go) begin
        grant_id   <= winner;
        last_grant <= winner;
        tx_data    <= frame_in[int'(winner)*FRAME_W +: FRAME_W];
      end
      if (state == LAUNCH)
        tmo_cnt <= '0;
      else if ((state == WAIT_DONE) && tx_busy && (tmo_cnt != TMO_LAST))
        tmo_cnt <= tmo_cnt + 1'b1;
      if (state != GAP)
        gap_cnt <= 8'd0;
      else
        gap_cnt <= gap_cnt + 8'd1;
      if (frame_tmo)
        tmo_err <= 1'b1;
      // A timed-out frame is not counted as completed.
      if (frame_done)
        frame_cnt <= frame_cnt + 16'd1;
    end
  end

  always_comb begin
    ack = '0;
    if (state == LAUNCH) ack[grant_id] = 1'b1;
    tx_ena    = (state == LAUNCH);
    active    = (state == LAUNCH) || (state == WAIT_DONE);
    state_dbg = state;
  end

endmodule

// File: tb/tb_tx_frame_sched.sv
// Directed bench for tx_frame_sched: reset, round-robin, gap timing, timeout,
// mid-frame reset and frame counter wrap, against a simple transmitter model.
`timescale 1ns/1ps

module tb_tx_frame_sched;

  localparam int N_SRC   = 4;
  localparam int FRAME_W = 16;
  localparam int GAP_CYC = 2;
  localparam int TMO_CYC = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic                     clk;
  logic                     rst;
  logic [N_SRC-1:0]         req;
  logic [N_SRC*FRAME_W-1:0] frame_in;
  logic [N_SRC-1:0]         ack;
  logic [FRAME_W-1:0]       tx_data;
  logic                     tx_ena;
  logic                     tx_busy;
  logic [1:0]               grant_id;
  logic                     active;
  logic                     tmo_err;
  logic [15:0]              frame_cnt;
  logic [1:0]               state_dbg;

  logic [FRAME_W-1:0] frm [N_SRC];
  int unsigned tx_len;
  int unsigned busy_left = 0;
  logic        stuck;
  int          errors = 0;
  int          checks = 0;

  tx_frame_sched #(
    .N_SRC(N_SRC), .FRAME_W(FRAME_W), .GAP_CYC(GAP_CYC), .TMO_CYC(TMO_CYC)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .frame_in(frame_in), .ack(ack),
    .tx_data(tx_data), .tx_ena(tx_ena), .tx_busy(tx_busy), .grant_id(grant_id),
    .active(active), .tmo_err(tmo_err), .frame_cnt(frame_cnt), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // transmitter model: busy with the strobe, then for tx_len more clocks
  assign frame_in = {frm[3], frm[2], frm[1], frm[0]};
  assign tx_busy  = tx_ena | stuck | (busy_left != 0);

  always @(posedge clk) begin
    if (tx_ena)
      busy_left <= tx_len;
    else if (busy_left != 0)
      busy_left <= busy_left - 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ena(input string tag, input int max, output int n);
    n = 0;
    while (tx_ena !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(tx_ena), 32'd1);
  endtask

  initial begin
    int n;
    int exp_id;
    logic prev_busy;

    rst = 1'b1; req = '0; stuck = 1'b0; tx_len = 2;
    frm[0] = 16'hA5A5; frm[1] = 16'h5A01; frm[2] = 16'hC302; frm[3] = 16'h3C03;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_tx_ena",  32'(tx_ena),    32'd0);
    check("rst_ack",     32'(ack),       32'd0);
    check("rst_active",  32'(active),    32'd0);
    check("rst_tmo_err", 32'(tmo_err),   32'd0);
    check("rst_cnt",     32'(frame_cnt), 32'd0);
    check("rst_data",    32'(tx_data),   32'd0);
    check("rst_gid",     32'(grant_id),  32'd0);
    check("rst_state",   32'(state_dbg), 32'(S_IDLE));
    rst = 1'b0;

    // single request from source 0: IDLE sees it, launch the following cycle
    req = 4'b0001;
    @(negedge clk);
    check("t1_launch", 32'(tx_ena),   32'd1);
    check("t1_ack",    32'(ack),      32'h1);
    check("t1_data",   32'(tx_data),  32'hA5A5);
    check("t1_gid",    32'(grant_id), 32'd0);
    check("t1_active", 32'(active),   32'd1);
    req = 4'b0000;
    @(negedge clk);
    check("t1_ack_one",  32'(ack),    32'd0);
    check("t1_ena_one",  32'(tx_ena), 32'd0);
    check("t1_act_wait", 32'(active), 32'd1);
    repeat (3) @(negedge clk);
    check("t1_cnt",      32'(frame_cnt), 32'd1);
    check("t1_act_gap",  32'(active),    32'd0);
    check("t1_state_gap", 32'(state_dbg), 32'(S_GAP));

    // round robin from reset with all sources requesting
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tx_len = 1;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ena("t2_launch", 20, n);
      exp_id = k % 4;
      check("t2_gid",  32'(grant_id), 32'(exp_id));
      check("t2_ack",  32'(ack),      32'd1 << exp_id);
      check("t2_data", 32'(tx_data),  32'(frm[exp_id]));
      @(negedge clk);
      check("t2_ack_one", 32'(ack), 32'd0);
    end

    // busy fall to next launch: GAP, GAP, IDLE, LAUNCH
    tx_len = 2;
    wait_ena("t3_launch6", 20, n);
    check("t3_gid6", 32'(grant_id), 32'd1);
    n = 0;
    while (tx_busy && n < 20) begin @(negedge clk); n++; end
    check("t3_busy_fall", 32'(tx_busy), 32'd0);
    n = 0;
    while (!tx_ena && n < 20) begin @(negedge clk); n++; end
    check("t3_fall_to_ena", 32'(n), 32'd4);
    check("t3_gid7", 32'(grant_id), 32'd2);
    req = 4'b0000;

    // a request appearing only during GAP is not sampled
    n = 0;
    while (tx_busy && n < 20) begin @(negedge clk); n++; end
    check("t3_busy_fall7", 32'(tx_busy), 32'd0);
    req = 4'b1000;
    @(negedge clk);
    check("t3_gap1", 32'(state_dbg), 32'(S_GAP));
    @(negedge clk);
    check("t3_gap2", 32'(state_dbg), 32'(S_GAP));
    req = 4'b0000;
    @(negedge clk);
    check("t3_idle",    32'(state_dbg), 32'(S_IDLE));
    check("t3_no_ena",  32'(tx_ena),    32'd0);
    @(negedge clk);
    check("t3_no_ena2", 32'(tx_ena),    32'd0);
    check("t3_cnt",     32'(frame_cnt), 32'd7);

    // transmitter stuck busy: timeout after TMO_CYC waiting clocks
    req = 4'b0010;
    wait_ena("t4_launch", 10, n);
    check("t4_gid", 32'(grant_id), 32'd1);
    stuck = 1'b1;
    req = 4'b0000;
    n = 0;
    while (!tmo_err && n < 100) begin @(negedge clk); n++; end
    check("t4_tmo_lat",  32'(n),         32'(TMO_CYC + 1));
    check("t4_cnt_hold", 32'(frame_cnt), 32'd7);
    check("t4_state",    32'(state_dbg), 32'(S_GAP));
    req = 4'b0001;
    repeat (4) @(negedge clk);
    check("t4_idle_busy", 32'(state_dbg), 32'(S_IDLE));
    check("t4_no_ena",    32'(tx_ena),    32'd0);
    stuck = 1'b0;
    wait_ena("t4_relaunch", 10, n);
    check("t4_gid2",   32'(grant_id), 32'd0);
    check("t4_sticky", 32'(tmo_err),  32'd1);
    req = 4'b0000;
    repeat (6) @(negedge clk);
    check("t4_cnt", 32'(frame_cnt), 32'd8);

    // reset while waiting for the transmitter
    tx_len = 6;
    req = 4'b0010;
    wait_ena("t5_launch", 10, n);
    check("t5_gid", 32'(grant_id), 32'd1);
    repeat (2) @(negedge clk);
    check("t5_wait", 32'(state_dbg), 32'(S_WAIT));
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_ena",   32'(tx_ena),    32'd0);
    check("t5_rst_ack",   32'(ack),       32'd0);
    check("t5_rst_act",   32'(active),    32'd0);
    check("t5_rst_tmo",   32'(tmo_err),   32'd0);
    check("t5_rst_cnt",   32'(frame_cnt), 32'd0);
    check("t5_rst_data",  32'(tx_data),   32'd0);
    check("t5_rst_gid",   32'(grant_id),  32'd0);
    check("t5_rst_state", 32'(state_dbg), 32'(S_IDLE));
    check("t5_busy_held", 32'(tx_busy),   32'd1);
    rst = 1'b0;
    n = 0;
    prev_busy = tx_busy;
    while (!tx_ena && n < 30) begin
      prev_busy = tx_busy;
      @(negedge clk);
      n++;
    end
    check("t5_relaunch",  32'(tx_ena),    32'd1);
    check("t5_prev_idle", 32'(prev_busy), 32'd0);
    check("t5_gid2",      32'(grant_id),  32'd1);
    check("t5_ack",       32'(ack),       32'h2);
    check("t5_data",      32'(tx_data),   32'(frm[1]));
    req = 4'b0000;
    repeat (10) @(negedge clk);
    check("t5_cnt", 32'(frame_cnt), 32'd1);

    // frame counter wraps from 0xFFFF to 0
    force dut.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt;
    @(negedge clk);
    check("t6_preset", 32'(frame_cnt), 32'hFFFF);
    tx_len = 1;
    req = 4'b0001;
    wait_ena("t6_launch", 10, n);
    req = 4'b0000;
    repeat (4) @(negedge clk);
    check("t6_wrap", 32'(frame_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
